// File: rtl/tile_grid_pkg.sv
// Shared types and constants for the tile-map controller.
// RGB332 colours, FSM states and tile index helper.
package tile_grid_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam logic [7:0] RGB_BG     = 8'b000_000_00;
  localparam logic [7:0] RGB_LINE   = 8'b111_111_11;
  localparam logic [7:0] RGB_CURSOR = 8'b111_000_00;

  function automatic logic [5:0] tile_idx(
    input logic [2:0] x,
    input logic [2:0] y,
    input int         w
  );
    return ({3'd0, y} * 6'(w)) + {3'd0, x};
  endfunction

endpackage

// File: rtl/tile_grid_ctrl_if.sv
// Tile write port: valid/ready handshake plus tile address and colour.
// Master is the maze/robot logic, slave is the tile controller.
interface tile_grid_ctrl_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_x;
  logic [2:0] wr_y;
  logic [7:0] wr_color;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color,
    output wr_ready
  );

endinterface

// File: rtl/tile_mem.sv
// N x W tile RAM: one write port, one registered read port.
// Read-before-write so it maps onto block RAM.
module tile_mem #(
  parameter int N  = 20,
  parameter int AW = 5,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_grid_ctrl.sv
// Tile-map controller: tile writes, clear walk, cursor blink and
// a 2-stage pixel pipeline into the VGA colour input.
module tile_grid_ctrl
  import tile_grid_pkg::*;
#(
  parameter int          GRID_W       = 4,
  parameter int          GRID_H       = 5,
  parameter int          TILE_LOG2    = 6,
  parameter int          BLINK_CYCLES = 12500000,
  parameter logic [7:0]  BG_COLOR     = RGB_BG,
  parameter logic [7:0]  LINE_COLOR   = RGB_LINE,
  parameter logic [7:0]  CURSOR_COLOR = RGB_CURSOR
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [9:0]        PIXEL_X,
  input  logic [9:0]        PIXEL_Y,
  output logic [7:0]        PIXEL_COLOR_OUT,
  tile_grid_ctrl_if.slave   wr,
  input  logic              clr_req,
  output logic              busy,
  output logic              err_oob,
  input  logic              cur_en,
  input  logic [2:0]        cur_x,
  input  logic [2:0]        cur_y,
  output logic              blink
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int SW = 10 - TILE_LOG2;

  state_t        state, state_nx;
  logic [AW-1:0] clr_idx, clr_idx_nx;
  logic          wr_ready_c;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    busy       = 1'b0;
    wr_ready_c = 1'b0;
    unique case (state)
      CLEAR: begin
        busy       = 1'b1;
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == AW'(N - 1)) begin
          state_nx   = IDLE;
          clr_idx_nx = '0;
        end
      end
      IDLE: begin
        wr_ready_c = ~clr_req;
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_idx_nx = '0;
        end
      end
    endcase
  end

  assign wr.wr_ready = wr_ready_c;

  logic       wr_fire;
  logic       wr_inb;
  logic [5:0] wr_idx;

  assign wr_fire = wr.wr_valid & wr_ready_c;
  assign wr_inb  = ({1'b0, wr.wr_x} < 4'(GRID_W))
                 & ({1'b0, wr.wr_y} < 4'(GRID_H));
  assign wr_idx  = tile_idx(wr.wr_x, wr.wr_y, GRID_W);

  always_ff @(posedge CLOCK) begin
    if (RESET)
      err_oob <= 1'b0;
    else
      err_oob <= wr_fire & ~wr_inb;
  end

  logic [CW-1:0] blk_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      blk_cnt <= '0;
      blink   <= 1'b1;
    end else if (blk_cnt == CW'(BLINK_CYCLES - 1)) begin
      blk_cnt <= '0;
      blink   <= ~blink;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  // Stage 1: tile coordinates on the full shifted width.
  logic [SW-1:0] tx_f, ty_f;
  logic          in_c, on_edge_c;
  logic [5:0]    rd_idx;
  logic [AW-1:0] rd_addr;

  assign tx_f      = PIXEL_X[9:TILE_LOG2];
  assign ty_f      = PIXEL_Y[9:TILE_LOG2];
  assign in_c      = (tx_f < SW'(GRID_W)) & (ty_f < SW'(GRID_H));
  assign on_edge_c = (PIXEL_X[TILE_LOG2-1:0] == '0)
                   | (PIXEL_Y[TILE_LOG2-1:0] == '0);
  assign rd_idx    = tile_idx(tx_f[2:0], ty_f[2:0], GRID_W);
  assign rd_addr   = in_c ? AW'(rd_idx) : '0;

  logic       mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0] mem_wd;
  logic [7:0] mem_rd;

  assign mem_we = busy | (wr_fire & wr_inb);
  assign mem_wa = busy ? clr_idx : AW'(wr_idx);
  assign mem_wd = busy ? BG_COLOR : wr.wr_color;

  tile_mem #(
    .N  (N),
    .AW (AW),
    .W  (8)
  ) u_mem (
    .clk   (CLOCK),
    .we    (mem_we),
    .waddr (mem_wa),
    .wdata (mem_wd),
    .raddr (rd_addr),
    .rdata (mem_rd)
  );

  logic [2:0] s1_tx, s1_ty;
  logic       s1_in, s1_edge;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1_tx   <= '0;
      s1_ty   <= '0;
      s1_in   <= 1'b0;
      s1_edge <= 1'b0;
    end else begin
      s1_tx   <= tx_f[2:0];
      s1_ty   <= ty_f[2:0];
      s1_in   <= in_c;
      s1_edge <= on_edge_c;
    end
  end

  // Stage 2: priority mux flattened into exclusive selects.
  logic       cur_hit;
  logic       sel_bg, sel_line, sel_cur, sel_mem;
  logic [7:0] pix_nx;

  assign cur_hit  = cur_en & blink
                  & (s1_tx == cur_x) & (s1_ty == cur_y);
  assign sel_bg   = ~s1_in;
  assign sel_line = s1_in & s1_edge;
  assign sel_cur  = s1_in & ~s1_edge & cur_hit;
  assign sel_mem  = s1_in & ~s1_edge & ~cur_hit;

  always_comb begin
    pix_nx = BG_COLOR;
    unique case (1'b1)
      sel_bg:   pix_nx = BG_COLOR;
      sel_line: pix_nx = LINE_COLOR;
      sel_cur:  pix_nx = CURSOR_COLOR;
      sel_mem:  pix_nx = mem_rd;
      default:  pix_nx = BG_COLOR;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET)
      PIXEL_COLOR_OUT <= '0;
    else
      PIXEL_COLOR_OUT <= pix_nx;
  end

endmodule

// File: tb/tb_tile_grid_ctrl.sv
// Self-checking bench for tile_grid_ctrl: scoreboard of pixel colours,
// clear timing, write range checks and cursor blink.
module tb_tile_grid_ctrl;

  localparam logic [7:0] BG  = 8'h00;
  localparam logic [7:0] LN  = 8'hFF;
  localparam logic [7:0] CUR = 8'hE0;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] PIXEL_X = '0;
  logic [9:0] PIXEL_Y = '0;
  logic [7:0] PIXEL_COLOR_OUT;
  logic       clr_req = 1'b0;
  logic       busy;
  logic       err_oob;
  logic       cur_en = 1'b0;
  logic [2:0] cur_x = '0;
  logic [2:0] cur_y = '0;
  logic       blink;

  tile_grid_ctrl_if wr();

  always #20 CLOCK = ~CLOCK;

  tile_grid_ctrl #(
    .GRID_W       (4),
    .GRID_H       (5),
    .TILE_LOG2    (6),
    .BLINK_CYCLES (4),
    .BG_COLOR     (BG),
    .LINE_COLOR   (LN),
    .CURSOR_COLOR (CUR)
  ) dut (
    .CLOCK           (CLOCK),
    .RESET           (RESET),
    .PIXEL_X         (PIXEL_X),
    .PIXEL_Y         (PIXEL_Y),
    .PIXEL_COLOR_OUT (PIXEL_COLOR_OUT),
    .wr              (wr),
    .clr_req         (clr_req),
    .busy            (busy),
    .err_oob         (err_oob),
    .cur_en          (cur_en),
    .cur_x           (cur_x),
    .cur_y           (cur_y),
    .blink           (blink)
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  logic [7:0] mm [20];
  logic [7:0] sb [$];

  // Edges since reset release; blink phase is 4 edges long.
  always @(posedge CLOCK) begin
    if (RESET) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  function automatic bit mblink();
    return ((ncyc / 4) % 2) == 0;
  endfunction

  function automatic logic [7:0] exp_pix(int x, int y, bit bl);
    int tx, ty;
    tx = x / 64;
    ty = y / 64;
    if (tx >= 4 || ty >= 5) return BG;
    if ((x % 64) == 0 || (y % 64) == 0) return LN;
    if (cur_en && bl && tx == int'(cur_x) && ty == int'(cur_y)) return CUR;
    return mm[ty * 4 + tx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 20; i++) mm[i] = BG;
  endtask

  task automatic do_write(int x, int y, logic [7:0] c);
    @(negedge CLOCK);
    wr.wr_valid = 1'b1;
    wr.wr_x     = 3'(x);
    wr.wr_y     = 3'(y);
    wr.wr_color = c;
    @(negedge CLOCK);
    wr.wr_valid = 1'b0;
    if (x < 4 && y < 5) mm[y * 4 + x] = c;
  endtask

  task automatic test_reset();
    int cnt;
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    total++;
    if (busy !== 1'b1 || wr.wr_ready !== 1'b0 || err_oob !== 1'b0 ||
        blink !== 1'b1 || PIXEL_COLOR_OUT !== 8'h00) begin
      bad++;
      $display("FAIL reset_vals busy=%b rdy=%b err=%b blink=%b pix=%h want 1 0 0 1 00",
               busy, wr.wr_ready, err_oob, blink, PIXEL_COLOR_OUT);
    end
    RESET = 1'b0;
    clear_model();
    cnt = 0;
    do begin
      @(negedge CLOCK);
      cnt++;
    end while (busy === 1'b1 && cnt < 100);
    total++;
    if (cnt != 20) begin
      bad++;
      $display("FAIL reset_busy_len got %0d want 20", cnt);
    end
    total++;
    if (wr.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b want 1", wr.wr_ready);
    end
  endtask

  task automatic test_scan(string nm, int step);
    int xs[$];
    int ys[$];
    int n;
    logic [7:0] e;
    for (int y = 0; y < 480; y += step)
      for (int x = 0; x < 640; x += step) begin
        xs.push_back(x);
        ys.push_back(y);
      end
    xs.push_back(64);  ys.push_back(10);
    xs.push_back(63);  ys.push_back(10);
    xs.push_back(256); ys.push_back(10);
    xs.push_back(10);  ys.push_back(320);
    xs.push_back(255); ys.push_back(319);
    n = xs.size();
    sb.delete();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLOCK);
      if (i >= 2) begin
        e = sb.pop_front();
        total++;
        if (PIXEL_COLOR_OUT !== e) begin
          bad++;
          $display("FAIL %s pix(%0d,%0d) got %h want %h",
                   nm, xs[i-2], ys[i-2], PIXEL_COLOR_OUT, e);
        end
      end
      if (i < n) begin
        PIXEL_X = 10'(xs[i]);
        PIXEL_Y = 10'(ys[i]);
        sb.push_back(exp_pix(xs[i], ys[i], 1'b0));
      end
    end
  endtask

  task automatic test_write();
    int px[4];
    int py[4];
    logic [7:0] e;
    px = '{100, 320, 100, 64};
    py = '{150, 10, 150, 10};
    do_write(1, 2, 8'h1C);
    total++;
    if (err_oob !== 1'b0) begin
      bad++;
      $display("FAIL write_err got %b want 0", err_oob);
    end
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      if (i >= 2) begin
        e = sb.pop_front();
        total++;
        if (PIXEL_COLOR_OUT !== e) begin
          bad++;
          $display("FAIL write_pix(%0d,%0d) got %h want %h",
                   px[i-2], py[i-2], PIXEL_COLOR_OUT, e);
        end
      end
      if (i < 4) begin
        PIXEL_X = 10'(px[i]);
        PIXEL_Y = 10'(py[i]);
        sb.push_back(i == 1 ? BG : (i == 3 ? LN : 8'h1C));
      end
    end
  endtask

  task automatic test_oob();
    do_write(5, 0, 8'hFF);
    total++;
    if (err_oob !== 1'b1) begin
      bad++;
      $display("FAIL oob_pulse got %b want 1", err_oob);
    end
    @(negedge CLOCK);
    total++;
    if (err_oob !== 1'b0) begin
      bad++;
      $display("FAIL oob_pulse_end got %b want 0", err_oob);
    end
    test_scan("oob_readback", 16);
  endtask

  task automatic test_clear_collision();
    int cnt;
    @(negedge CLOCK);
    clr_req     = 1'b1;
    wr.wr_valid = 1'b1;
    wr.wr_x     = 3'd0;
    wr.wr_y     = 3'd0;
    wr.wr_color = 8'h55;
    #1;
    total++;
    if (wr.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL clr_ready got %b want 0", wr.wr_ready);
    end
    @(negedge CLOCK);
    clr_req     = 1'b0;
    wr.wr_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clr_busy_rise got %b want 1", busy);
    end
    clear_model();
    cnt = 0;
    do begin
      @(negedge CLOCK);
      cnt++;
      clr_req = (cnt >= 4 && cnt < 7);
    end while (busy === 1'b1 && cnt < 100);
    clr_req = 1'b0;
    total++;
    if (cnt != 20) begin
      bad++;
      $display("FAIL clr_busy_len got %0d want 20", cnt);
    end
    test_scan("clr_readback", 16);
  endtask

  task automatic test_cursor();
    bit pb;
    logic [7:0] e;
    do_write(0, 0, 8'h2A);
    cur_en  = 1'b1;
    cur_x   = 3'd0;
    cur_y   = 3'd0;
    PIXEL_X = 10'd10;
    PIXEL_Y = 10'd10;
    repeat (2) @(negedge CLOCK);
    pb = mblink();
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK);
      e = pb ? CUR : 8'h2A;
      total++;
      if (PIXEL_COLOR_OUT !== e) begin
        bad++;
        $display("FAIL cursor_pix cyc%0d got %h want %h", i, PIXEL_COLOR_OUT, e);
      end
      total++;
      if (blink !== mblink()) begin
        bad++;
        $display("FAIL cursor_blink cyc%0d got %b want %b", i, blink, mblink());
      end
      pb = mblink();
    end
    cur_x = 3'd7;
    cur_y = 3'd7;
    @(negedge CLOCK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      total++;
      if (PIXEL_COLOR_OUT !== 8'h2A) begin
        bad++;
        $display("FAIL cursor_oob cyc%0d got %h want 2a", i, PIXEL_COLOR_OUT);
      end
    end
    cur_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_write(2, 3, 8'h77);
    @(negedge CLOCK);
    clr_req = 1'b1;
    @(negedge CLOCK);
    clr_req = 1'b0;
    repeat (7) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_busy got %b want 1", busy);
    end
    RESET = 1'b0;
    clear_model();
    cnt = 0;
    do begin
      @(negedge CLOCK);
      cnt++;
    end while (busy === 1'b1 && cnt < 100);
    total++;
    if (cnt != 20) begin
      bad++;
      $display("FAIL mid_reset_len got %0d want 20", cnt);
    end
    test_scan("mid_readback", 16);
  endtask

  initial begin
    wr.wr_valid = 1'b0;
    wr.wr_x     = '0;
    wr.wr_y     = '0;
    wr.wr_color = '0;
    clear_model();
    test_reset();
    test_scan("reset_scan", 7);
    test_write();
    test_oob();
    test_clear_collision();
    test_cursor();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
